// File: rtl/alu_ctrl_stage_pkg.sv
// Shared definitions for the ALU/control stage: opcodes, ALU operation codes
// and the decoded control bundle.
package alu_ctrl_stage_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ALUOP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD  = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b000001;
  localparam logic [OP_W-1:0] OP_SUB  = 6'b000010;
  localparam logic [OP_W-1:0] OP_ORI  = 6'b010000;
  localparam logic [OP_W-1:0] OP_AND  = 6'b010001;
  localparam logic [OP_W-1:0] OP_OR   = 6'b010010;
  localparam logic [OP_W-1:0] OP_MOVE = 6'b100000;
  localparam logic [OP_W-1:0] OP_SW   = 6'b100110;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100111;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b110000;
  localparam logic [OP_W-1:0] OP_HALT = 6'b111111;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_RSUB = 3'b010,
    ALU_OR   = 3'b011,
    ALU_AND  = 3'b100,
    ALU_ANDN = 3'b101,
    ALU_XOR  = 3'b110,
    ALU_XNOR = 3'b111
  } alu_op_e;

  // Opcode-only decode; PCSrc is derived later from is_beq and the ALU zero flag.
  typedef struct packed {
    logic    reg_wre;
    logic    pc_wre;
    logic    alu_src_b;
    logic    alu_m2reg;
    logic    reg_out;
    logic    data_mem_rw;
    logic    ext_sel;
    logic    is_beq;
    alu_op_e alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    reg_wre:     1'b0,
    pc_wre:      1'b1,
    alu_src_b:   1'b0,
    alu_m2reg:   1'b0,
    reg_out:     1'b0,
    data_mem_rw: 1'b0,
    ext_sel:     1'b0,
    is_beq:      1'b0,
    alu_op:      ALU_ADD
  };

endpackage

// File: rtl/alu32.sv
// Combinational 32-bit ALU; arithmetic wraps modulo 2^32.
module alu32
  import alu_ctrl_stage_pkg::*;
(
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  input  logic [ALUOP_W-1:0] s,
  output logic [DATA_W-1:0]  result,
  output logic               zero
);

  always_comb begin
    result = '0;
    case (s)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_RSUB: result = b - a;
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      ALU_ANDN: result = ~a & b;
      ALU_XOR:  result = a ^ b;
      ALU_XNOR: result = ~(a ^ b);
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_ctrl_stage.sv
// Single-cycle datapath slice: opcode decode, ALU with operand-B select,
// and a one-cycle result register.
module alu_ctrl_stage
  import alu_ctrl_stage_pkg::*;
(
  input  logic               clk,
  input  logic               Reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic [DATA_W-1:0]  rs_data,
  input  logic [DATA_W-1:0]  rt_data,
  input  logic [DATA_W-1:0]  ext_out,
  output logic               RegWre,
  output logic               PCWre,
  output logic               ALUSrcB,
  output logic               ALUM2Reg,
  output logic               RegOut,
  output logic               DataMemRw,
  output logic               PCSrc,
  output logic               ExtSel,
  output logic               InsMemRW,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [DATA_W-1:0]  alu_result,
  output logic               zero,
  output logic [DATA_W-1:0]  alu_cache_data_out
);

  ctrl_t             w_ctrl;
  logic [DATA_W-1:0] w_op_b;
  logic [DATA_W-1:0] w_result;
  logic              w_zero;
  logic [DATA_W-1:0] r_cache;

  // Opcode decode; unlisted opcodes fall through as NOP.
  always_comb begin
    w_ctrl = CTRL_NOP;
    case (opcode)
      OP_ADD, OP_MOVE: begin
        w_ctrl.reg_wre = 1'b1;
        w_ctrl.reg_out = 1'b1;
      end
      OP_ADDI: begin
        w_ctrl.reg_wre   = 1'b1;
        w_ctrl.alu_src_b = 1'b1;
        w_ctrl.ext_sel   = 1'b1;
      end
      OP_SUB: begin
        w_ctrl.reg_wre = 1'b1;
        w_ctrl.reg_out = 1'b1;
        w_ctrl.alu_op  = ALU_SUB;
      end
      OP_ORI: begin
        w_ctrl.reg_wre   = 1'b1;
        w_ctrl.alu_src_b = 1'b1;
        w_ctrl.alu_op    = ALU_OR;
      end
      OP_AND: begin
        w_ctrl.reg_wre = 1'b1;
        w_ctrl.reg_out = 1'b1;
        w_ctrl.alu_op  = ALU_AND;
      end
      OP_OR: begin
        w_ctrl.reg_wre = 1'b1;
        w_ctrl.reg_out = 1'b1;
        w_ctrl.alu_op  = ALU_OR;
      end
      OP_SW: begin
        w_ctrl.alu_src_b   = 1'b1;
        w_ctrl.data_mem_rw = 1'b1;
        w_ctrl.ext_sel     = 1'b1;
      end
      OP_LW: begin
        w_ctrl.reg_wre   = 1'b1;
        w_ctrl.alu_src_b = 1'b1;
        w_ctrl.alu_m2reg = 1'b1;
        w_ctrl.ext_sel   = 1'b1;
      end
      OP_BEQ: begin
        w_ctrl.ext_sel = 1'b1;
        w_ctrl.is_beq  = 1'b1;
        w_ctrl.alu_op  = ALU_SUB;
      end
      OP_HALT: begin
        w_ctrl.pc_wre = 1'b0;
      end
      default: w_ctrl = CTRL_NOP;
    endcase
  end

  assign w_op_b = w_ctrl.alu_src_b ? ext_out : rt_data;

  alu32 u_alu (
    .a      (rs_data),
    .b      (w_op_b),
    .s      (w_ctrl.alu_op),
    .result (w_result),
    .zero   (w_zero)
  );

  // Result register: reset clears it, otherwise it reloads every edge.
  always_ff @(posedge clk) begin
    if (Reset) r_cache <= '0;
    else       r_cache <= w_result;
  end

  assign RegWre             = w_ctrl.reg_wre;
  assign PCWre              = w_ctrl.pc_wre;
  assign ALUSrcB            = w_ctrl.alu_src_b;
  assign ALUM2Reg           = w_ctrl.alu_m2reg;
  assign RegOut             = w_ctrl.reg_out;
  assign DataMemRw          = w_ctrl.data_mem_rw;
  assign ExtSel             = w_ctrl.ext_sel;
  assign PCSrc              = w_ctrl.is_beq & w_zero;
  assign InsMemRW           = 1'b1;
  assign ALUOp              = w_ctrl.alu_op;
  assign alu_result         = w_result;
  assign zero               = w_zero;
  assign alu_cache_data_out = r_cache;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed bench for alu_ctrl_stage: decode/ALU vector table, a direct ALU
// operation sweep, and hand sequences for the result register and reset.
module tb_alu_ctrl_stage;

  logic        clk = 1'b0;
  logic        Reset;
  logic [5:0]  opcode;
  logic [31:0] rs_data, rt_data, ext_out;
  logic        RegWre, PCWre, ALUSrcB, ALUM2Reg, RegOut, DataMemRw, PCSrc, ExtSel, InsMemRW;
  logic [2:0]  ALUOp;
  logic [31:0] alu_result, alu_cache_data_out;
  logic        zero;

  logic [31:0] sa, sb, sres;
  logic [2:0]  ss;
  logic        sz;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_ctrl_stage dut (
    .clk(clk), .Reset(Reset), .opcode(opcode),
    .rs_data(rs_data), .rt_data(rt_data), .ext_out(ext_out),
    .RegWre(RegWre), .PCWre(PCWre), .ALUSrcB(ALUSrcB), .ALUM2Reg(ALUM2Reg),
    .RegOut(RegOut), .DataMemRw(DataMemRw), .PCSrc(PCSrc), .ExtSel(ExtSel),
    .InsMemRW(InsMemRW), .ALUOp(ALUOp), .alu_result(alu_result), .zero(zero),
    .alu_cache_data_out(alu_cache_data_out)
  );

  alu32 u_alu_sweep (.a(sa), .b(sb), .s(ss), .result(sres), .zero(sz));

  // Control order: RegWre PCWre ALUSrcB ALUM2Reg RegOut DataMemRw PCSrc ExtSel InsMemRW ALUOp[2:0]
  typedef struct {
    logic [5:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] ext;
    logic [11:0] ctrl;
    logic [31:0] res;
    logic        z;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  function automatic logic [11:0] ctrl_now();
    return {RegWre, PCWre, ALUSrcB, ALUM2Reg, RegOut, DataMemRw, PCSrc, ExtSel, InsMemRW, ALUOp};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] ext);
    opcode = op; rs_data = rs; rt_data = rt; ext_out = ext;
    #1;
  endtask

  initial begin
    vecs[0]  = '{6'b000000, 32'h5,        32'h3,        32'h0,        12'b1_1_0_0_1_0_0_0_1_000, 32'h8,        1'b0};
    vecs[1]  = '{6'b110000, 32'h1234,     32'h1234,     32'h0,        12'b0_1_0_0_0_0_1_1_1_001, 32'h0,        1'b1};
    vecs[2]  = '{6'b110000, 32'h1234,     32'h1235,     32'h0,        12'b0_1_0_0_0_0_0_1_1_001, 32'hFFFFFFFF, 1'b0};
    vecs[3]  = '{6'b100111, 32'h10,       32'h99,       32'h4,        12'b1_1_1_1_0_0_0_1_1_000, 32'h14,       1'b0};
    vecs[4]  = '{6'b100110, 32'h10,       32'h99,       32'h4,        12'b0_1_1_0_0_1_0_1_1_000, 32'h14,       1'b0};
    vecs[5]  = '{6'b111111, 32'h5,        32'h3,        32'h77,       12'b0_0_0_0_0_0_0_0_1_000, 32'h8,        1'b0};
    vecs[6]  = '{6'b001111, 32'h7,        32'h9,        32'h100,      12'b0_1_0_0_0_0_0_0_1_000, 32'h10,       1'b0};
    vecs[7]  = '{6'b000010, 32'hA,        32'h3,        32'h0,        12'b1_1_0_0_1_0_0_0_1_001, 32'h7,        1'b0};
    vecs[8]  = '{6'b000010, 32'h3,        32'h5,        32'h0,        12'b1_1_0_0_1_0_0_0_1_001, 32'hFFFFFFFE, 1'b0};
    vecs[9]  = '{6'b010000, 32'hF0F0F0F0, 32'h0,        32'h0FF00FF0, 12'b1_1_1_0_0_0_0_0_1_011, 32'hFFF0FFF0, 1'b0};
    vecs[10] = '{6'b010001, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        12'b1_1_0_0_1_0_0_0_1_100, 32'h00F000F0, 1'b0};
    vecs[11] = '{6'b010010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        12'b1_1_0_0_1_0_0_0_1_011, 32'hFFF0FFF0, 1'b0};
    vecs[12] = '{6'b000001, 32'hFFFFFFFF, 32'h55,       32'h1,        12'b1_1_1_0_0_0_0_1_1_000, 32'h0,        1'b1};
    vecs[13] = '{6'b100000, 32'hABCD,     32'h0,        32'h9,        12'b1_1_0_0_1_0_0_0_1_000, 32'hABCD,     1'b0};
    vecs[14] = '{6'b000000, 32'hFFFFFFFF, 32'h1,        32'h0,        12'b1_1_0_0_1_0_0_0_1_000, 32'h0,        1'b1};
  end

  initial begin
    logic [31:0] sweep_exp[8];
    sweep_exp[0] = 32'h00E100E0; sweep_exp[1] = 32'hE100E100;
    sweep_exp[2] = 32'h1EFF1F00; sweep_exp[3] = 32'hFFF0FFF0;
    sweep_exp[4] = 32'h00F000F0; sweep_exp[5] = 32'h0F000F00;
    sweep_exp[6] = 32'hFF00FF00; sweep_exp[7] = 32'h00FF00FF;

    // Reset clears the register while combinational outputs keep following inputs.
    Reset = 1'b1;
    sa = '0; sb = '0; ss = '0;
    @(negedge clk);
    apply(6'b000000, 32'h20, 32'h2, 32'h0);
    @(posedge clk); #1;
    check("reset_cache", alu_cache_data_out, 32'h0);
    check("reset_comb_result", alu_result, 32'h22);
    check("reset_comb_ctrl", 32'(ctrl_now()), 32'(12'b1_1_0_0_1_0_0_0_1_000));
    Reset = 1'b0;

    // Vector table: combinational outputs, then the registered copy one edge later.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      apply(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].ext);
      check($sformatf("v%0d_ctrl", i), 32'(ctrl_now()), 32'(vecs[i].ctrl));
      check($sformatf("v%0d_result", i), alu_result, vecs[i].res);
      check($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].z));
      @(posedge clk); #1;
      check($sformatf("v%0d_cache", i), alu_cache_data_out, vecs[i].res);
    end

    // Direct ALU operation sweep including the codes no opcode reaches.
    sa = 32'hF0F0F0F0; sb = 32'h0FF00FF0;
    for (int k = 0; k < 8; k++) begin
      ss = 3'(k);
      #1;
      check($sformatf("sweep_op%0d", k), sres, sweep_exp[k]);
      check($sformatf("sweep_zero%0d", k), 32'(sz), 32'h0);
    end
    sa = 32'hFFFFFFFF; sb = 32'h1; ss = 3'b000;
    #1;
    check("sweep_wrap_result", sres, 32'h0);
    check("sweep_wrap_zero", 32'(sz), 32'h1);

    // Reset mid-operation loses only the registered value.
    @(negedge clk);
    apply(6'b000000, 32'hDEAD, 32'h0, 32'h0);
    @(posedge clk); #1;
    check("hold_dead", alu_cache_data_out, 32'hDEAD);
    @(negedge clk);
    Reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_cache", alu_cache_data_out, 32'h0);
    check("midreset_result", alu_result, 32'hDEAD);
    @(negedge clk);
    Reset = 1'b0;
    check("pre_reload_cache", alu_cache_data_out, 32'h0);
    @(posedge clk); #1;
    check("reload_cache", alu_cache_data_out, 32'hDEAD);

    // Register tracks a changing result every edge with no enable.
    @(negedge clk);
    apply(6'b000010, 32'h100, 32'h1, 32'h0);
    @(posedge clk); #1;
    check("track_cache", alu_cache_data_out, 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_ctrl_stage.md
ALU_CTRL_STAGE -- requirements
Module: alu_ctrl_stage

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 Reset  input  1  synchronous active-high reset; clears the result register only.
REQ-004 opcode  input  6  instruction[31:26].
REQ-005 rs_data  input  32  ALU operand A.
REQ-006 rt_data  input  32  ALU operand B when ALUSrcB=0.
REQ-007 ext_out  input  32  extended immediate; ALU operand B when ALUSrcB=1.
REQ-008 RegWre, PCWre, ALUSrcB, ALUM2Reg, RegOut, DataMemRw, PCSrc, ExtSel, InsMemRW  output  1 each  control signals per REQ-013.
REQ-009 ALUOp  output  3  ALU operation select.
REQ-010 alu_result  output  32  combinational ALU result.
REQ-011 zero  output  1  1 iff alu_result == 0.
REQ-012 alu_cache_data_out  output  32  registered copy of alu_result.

Function
REQ-013 Control decode SHALL be purely combinational. Fields: RegWre, ALUSrcB, ALUOp, ALUM2Reg, RegOut, DataMemRw, ExtSel, PCSrc; PCWre=1 unless stated.
- add 000000: 1,0,000,0,1,0,x,0
- addi 000001: 1,1,000,0,0,0,1,0
- sub 000010: 1,0,001,0,1,0,x,0
- ori 010000: 1,1,011,0,0,0,0,0
- and 010001: 1,0,100,0,1,0,x,0
- or 010010: 1,0,011,0,1,0,x,0
- move 100000: 1,0,000,0,1,0,x,0
- sw 100110: 0,1,000,0,0,1,1,0
- lw 100111: 1,1,000,1,0,0,1,0
- beq 110000: 0,0,001,0,0,0,1,PCSrc=zero
- halt 111111: all write enables 0, PCWre=0
REQ-014 Don't-care (x) outputs SHALL be driven 0.
REQ-015 Any unlisted opcode SHALL decode as a NOP: RegWre=0, DataMemRw=0, PCSrc=0, PCWre=1, ALUOp=000, and all other controls 0.
REQ-016 InsMemRW SHALL be constant 1 (instruction memory is read-only).
REQ-017 ALU operand B SHALL be ALUSrcB ? ext_out : rt_data.
REQ-018 ALUOp SHALL select the ALU operation:
- 000 A+B
- 001 A-B
- 010 B-A
- 011 A|B
- 100 A&B
- 101 ~A&B
- 110 A^B
- 111 ~(A^B)
REQ-019 ALU arithmetic SHALL be 32-bit modulo 2^32; overflow is ignored and carry is discarded.
REQ-020 zero SHALL be evaluated on the final 32-bit result, including after wrap-around.
REQ-021 For beq, PCSrc SHALL be a combinational function of zero in the same cycle.
REQ-022 alu_cache_data_out SHALL load alu_result on every rising clk edge, giving one-cycle latency; there is no enable.

Reset
REQ-023 While Reset=1 at a clk edge, alu_cache_data_out SHALL become 32'h0; Reset takes priority over the load.
REQ-024 Reset SHALL NOT affect the combinational outputs; all control outputs, alu_result and zero follow the inputs during reset.
REQ-025 A mid-operation Reset SHALL lose only the registered value; the next edge with Reset=0 loads the current alu_result.

Structure
REQ-026 A shared package SHALL hold the 6-bit opcode constants and the 3-bit ALUOp encodings.
REQ-027 The ALU SHALL be a sub-module named alu32, combinational, with ports a, b, s[2:0], result, zero.
REQ-028 Decode and the result register SHALL live in the top module.

Verification
REQ-029 add, rs_data=5, rt_data=3 -> RegWre=1, RegOut=1, ALUOp=000, alu_result=8, zero=0; alu_cache_data_out=8 after one edge.
REQ-030 beq with rs_data=rt_data=32'h1234 -> zero=1, PCSrc=1; with rt_data=32'h1235 -> alu_result=32'hFFFFFFFF, PCSrc=0.
REQ-031 lw, rs_data=32'h10, ext_out=32'h4 -> ALUSrcB=1, ALUM2Reg=1, ExtSel=1, alu_result=32'h14; sw with the same operands -> DataMemRw=1, RegWre=0.
REQ-032 Sweep ALUOp 000-111 with A=32'hF0F0F0F0, B=32'h0FF00FF0 and check each result against REQ-018; A=32'hFFFFFFFF, B=1, op 000 -> result 0, zero=1.
REQ-033 halt -> PCWre=0, RegWre=0, DataMemRw=0; opcode 6'b001111 -> NOP decode per REQ-015.
REQ-034 With the register holding 32'hDEAD, assert Reset for one edge -> 0 while alu_result is unchanged; deassert Reset -> loads alu_result at the next edge.
